// File: rtl/fft_buf_pkg.sv
// fft_buf_pkg: shared sizes, writer state and bit-reverse helper for the FFT frame buffers
package fft_buf_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;
  localparam int FRAME_LEN = 1 << DEF_ADDR_W;
  typedef enum logic {WAIT_SOF, FILL} wr_state_t;
  function automatic logic [31:0] bitrev(input logic [31:0] a, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = a[w-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_frame_capture_buf_if.sv
// fft_frame_capture_buf_if: sample stream in, addressed frame read out
interface fft_frame_capture_buf_if import fft_buf_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic in_start, in_valid, in_ready, overflow, frame_ready;
  logic rd_en, rd_valid, rd_release;
  logic [DATA_W-1:0] in_data, rd_data;
  logic [ADDR_W-1:0] rd_addr;
  modport master (
    output in_start, in_valid, in_data, rd_en, rd_addr, rd_release,
    input in_ready, overflow, frame_ready, rd_data, rd_valid
  );
  modport slave (
    input in_start, in_valid, in_data, rd_en, rd_addr, rd_release,
    output in_ready, overflow, frame_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/fft_buf_dpram.sv
// fft_buf_dpram: simple dual-port RAM, one write port, one registered ce-gated read port
module fft_buf_dpram #(
  parameter int DW = 32,
  parameter int AW = 9
) (
  input  logic          clock_c,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clock_c)
    if (ce & we) mem[waddr] <= wdata;
  always_ff @(posedge clock_c or negedge reset_n)
    if (!reset_n) rdata <= '0;
    else if (ce & re) rdata <= mem[raddr];
endmodule

// File: rtl/fft_frame_capture_buf.sv
// fft_frame_capture_buf: sequential-write / addressed-read ping-pong frame buffer.
// Define FFT_FRAME_BITREV_RD_EN to bit-reverse the read address.
module fft_frame_capture_buf import fft_buf_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic clock_c,
  input logic reset_n,
  input logic ce,
  fft_frame_capture_buf_if.slave bus
);
  wr_state_t state;
  logic wr_bank, rd_bank, acc, we, last, rel;
  logic [1:0] full;
  logic [ADDR_W-1:0] wr_cnt, wa, ra;
  assign bus.in_ready = ~full[wr_bank];
  assign bus.frame_ready = full[rd_bank];
  assign acc = ce & bus.in_valid & bus.in_ready;
  assign we = acc & (bus.in_start | state == FILL);
  assign wa = bus.in_start ? '0 : wr_cnt;
  assign last = we & (&wa);
  assign rel = ce & bus.rd_release & bus.frame_ready;
`ifdef FFT_FRAME_BITREV_RD_EN
  assign ra = ADDR_W'(bitrev(32'(bus.rd_addr), ADDR_W));
`else
  assign ra = bus.rd_addr;
`endif
  // completion and release always target different banks, so both may land in one cycle
  always_ff @(posedge clock_c or negedge reset_n)
    if (!reset_n) begin
      state <= WAIT_SOF;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full <= '0;
      wr_cnt <= '0;
      bus.overflow <= 1'b0;
      bus.rd_valid <= 1'b0;
    end else if (ce) begin
      if (we) begin
        state <= last ? WAIT_SOF : FILL;
        wr_cnt <= wa + 1'b1;
        if (last) begin
          full[wr_bank] <= 1'b1;
          wr_bank <= ~wr_bank;
        end
      end
      if (rel) begin
        full[rd_bank] <= 1'b0;
        rd_bank <= ~rd_bank;
      end
      bus.overflow <= bus.overflow | (bus.in_valid & ~bus.in_ready);
      bus.rd_valid <= bus.rd_en & bus.frame_ready;
    end
  fft_buf_dpram #(.DW(DATA_W), .AW(ADDR_W + 1)) u_ram (
    .clock_c(clock_c),
    .reset_n(reset_n),
    .ce(ce),
    .we(we),
    .waddr({wr_bank, wa}),
    .wdata(bus.in_data),
    .re(bus.rd_en),
    .raddr({rd_bank, ra}),
    .rdata(bus.rd_data)
  );
endmodule

// File: tb/tb_fft_frame_capture_buf.sv
// tb_fft_frame_capture_buf: scoreboard bench for the ping-pong frame capture buffer
module tb_fft_frame_capture_buf;
  import fft_buf_pkg::*;
  localparam int AW = DEF_ADDR_W;
  logic clock_c = 1'b0;
  logic reset_n = 1'b0;
  logic ce = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  fft_frame_capture_buf_if bus();
  fft_frame_capture_buf dut (.clock_c(clock_c), .reset_n(reset_n), .ce(ce), .bus(bus));
  always #5 clock_c = ~clock_c;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [AW-1:0] ea(input logic [AW-1:0] a);
`ifdef FFT_FRAME_BITREV_RD_EN
    for (int i = 0; i < AW; i++) ea[i] = a[AW-1-i];
`else
    ea = a;
`endif
  endfunction
  always @(negedge clock_c)
    if (reset_n && bus.rd_valid) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 32'(exp_q.size()), 1);
      else chk("rd_data", bus.rd_data, exp_q.pop_front());
    end
  task automatic drive(input logic s, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_start = s;
    bus.in_data = d;
    @(negedge clock_c);
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
  endtask
  task automatic send_range(input logic [31:0] base, input int lo, input int hi, input logic s0);
    for (int i = lo; i <= hi; i++) drive(s0 && i == lo, base + 32'(i));
  endtask
  task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp);
    bus.rd_en = 1'b1;
    bus.rd_addr = a;
    exp_q.push_back(exp);
    @(negedge clock_c);
    bus.rd_en = 1'b0;
    chk("rd_valid", bus.rd_valid, 1);
  endtask
  task automatic rel();
    bus.rd_release = 1'b1;
    @(negedge clock_c);
    bus.rd_release = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end
  initial begin
    bus.in_start = 0; bus.in_valid = 0; bus.in_data = 0;
    bus.rd_en = 0; bus.rd_addr = 0; bus.rd_release = 0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_frame_ready", bus.frame_ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_overflow", bus.overflow, 0);
    repeat (2) @(negedge clock_c);
    reset_n = 1'b1;
    @(negedge clock_c);
    // first frame: data equals address
    send_range(0, 0, FRAME_LEN - 2, 1);
    chk("f1_not_yet", bus.frame_ready, 0);
    drive(0, FRAME_LEN - 1);
    chk("f1_ready", bus.frame_ready, 1);
    chk("f1_in_ready", bus.in_ready, 1);
    rd(0, 32'(ea(0)));
    rd(17, 32'(ea(17)));
    rd(255, 32'(ea(255)));
    rd(1, 32'(ea(1)));
    rel();
    chk("f1_released", bus.frame_ready, 0);
    // samples before any in_start are discarded
    send_range(32'hDEAD0000, 0, 9, 0);
    chk("pre_sof_no_frame", bus.frame_ready, 0);
    send_range(32'h1000, 0, FRAME_LEN - 1, 1);
    chk("f2_ready", bus.frame_ready, 1);
    rd(0, 32'h1000 + 32'(ea(0)));
    rd(9, 32'h1000 + 32'(ea(9)));
    rd(100, 32'h1000 + 32'(ea(100)));
    // both banks full -> backpressure and overflow
    send_range(32'h2000, 0, FRAME_LEN - 1, 1);
    chk("both_full_in_ready", bus.in_ready, 0);
    chk("both_full_frame_ready", bus.frame_ready, 1);
    drive(1, 32'hBEEF);
    chk("overflow_set", bus.overflow, 1);
    bus.rd_release = 1'b1;
    rd(7, 32'h1000 + 32'(ea(7)));
    bus.rd_release = 1'b0;
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rel_frame_ready", bus.frame_ready, 1);
    rd(5, 32'h2000 + 32'(ea(5)));
    rel();
    chk("rel2_empty", bus.frame_ready, 0);
    // restart mid-frame at wr_cnt = 100
    send_range(32'h3000, 0, 99, 1);
    drive(1, 32'hAAAA);
    send_range(32'h4000, 1, FRAME_LEN - 2, 0);
    chk("restart_not_yet", bus.frame_ready, 0);
    drive(0, 32'h4000 + FRAME_LEN - 1);
    chk("restart_ready", bus.frame_ready, 1);
    rd(0, 32'hAAAA);
    rd(200, 32'h4000 + 32'(ea(200)));
    // release in the same cycle the other bank completes
    send_range(32'h5000, 0, FRAME_LEN - 2, 1);
    bus.rd_release = 1'b1;
    drive(0, 32'h5000 + FRAME_LEN - 1);
    bus.rd_release = 1'b0;
    chk("simul_frame_ready", bus.frame_ready, 1);
    chk("simul_in_ready", bus.in_ready, 1);
    rd(3, 32'h5000 + 32'(ea(3)));
    // ce low holds everything
    send_range(32'h6000, 0, 49, 1);
    ce = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hBAD;
    bus.rd_release = 1'b1;
    repeat (5) @(negedge clock_c);
    chk("ce_frame_ready", bus.frame_ready, 1);
    chk("ce_in_ready", bus.in_ready, 1);
    chk("ce_overflow_sticky", bus.overflow, 1);
    ce = 1'b1;
    bus.in_valid = 1'b0;
    bus.rd_release = 1'b0;
    send_range(32'h6000, 50, FRAME_LEN - 2, 0);
    chk("ce_cnt_held", bus.in_ready, 1);
    drive(0, 32'h6000 + FRAME_LEN - 1);
    chk("ce_completed", bus.in_ready, 0);
    rel();
    rd(50, 32'h6000 + 32'(ea(50)));
    rd(49, 32'h6000 + 32'(ea(49)));
    // reset mid-frame with one bank full
    send_range(32'h7000, 0, 49, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_frame_ready", bus.frame_ready, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_overflow", bus.overflow, 0);
    chk("arst_rd_valid", bus.rd_valid, 0);
    @(negedge clock_c);
    reset_n = 1'b1;
    @(negedge clock_c);
    send_range(32'hEE00, 0, 2, 0);
    send_range(32'h8000, 0, FRAME_LEN - 2, 1);
    chk("post_rst_not_yet", bus.frame_ready, 0);
    drive(0, 32'h8000 + FRAME_LEN - 1);
    chk("post_rst_ready", bus.frame_ready, 1);
    rd(2, 32'h8000 + 32'(ea(2)));
    repeat (2) @(negedge clock_c);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_frame_capture_buf.md
# fft_frame_capture_buf

Streaming-in, random-read ping-pong frame buffer for the 256-point FFT datapath. Accepts one sample per enabled cycle at sequentially generated addresses, delimited by a start-of-frame strobe. Once a frame is complete, the block exposes it to an address-driven reader (the butterfly/reorder stage) while the other bank fills. It is the write-sequential / read-addressed counterpart of the stage output buffer, which takes addressed writes and streams sequential reads.

## Interface
- DATA_W, 32, sample width (packed complex re/im)
- ADDR_W, 8, log2 of frame length (frame = 2^ADDR_W samples)
- clock_c  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; when low, all state holds except reset
- in_start  in  1  first sample of a frame, qualified by in_valid
- in_valid  in  1  in_data valid
- in_data  in  DATA_W  input sample
- in_ready  out  1  fill bank can accept samples
- overflow  out  1  sticky: in_valid while in_ready low (with ce); cleared only by reset
- frame_ready  out  1  complete frame held in read bank
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address within frame
- rd_data  out  DATA_W  read data, registered
- rd_valid  out  1  rd_data valid
- rd_release  in  1  reader finished with current frame

## Operation
- Two banks of 2^ADDR_W x DATA_W. Pointers wr_bank and rd_bank, both reset to 0. Per-bank full flags reset to 0.
- Writer FSM: WAIT_SOF (reset state) and FILL. Counter wr_cnt[ADDR_W-1:0] resets to 0.
- A sample is accepted when ce & in_valid & in_ready. in_ready = ~full[wr_bank].
- WAIT_SOF: accepted samples without in_start are discarded. An accepted sample with in_start is written to address 0, wr_cnt becomes 1, and the FSM goes to FILL.
- FILL: an accepted sample is written to wr_cnt and wr_cnt increments. An accepted in_start mid-frame restarts the frame: the sample goes to address 0 and wr_cnt becomes 1. Partial data is abandoned with no flag.
- Writing address 2^ADDR_W-1 sets full[wr_bank], toggles wr_bank, wraps wr_cnt to 0, and returns the FSM to WAIT_SOF.
- frame_ready = full[rd_bank]. When ce & rd_release & frame_ready, full[rd_bank] is cleared and rd_bank toggles. rd_release without frame_ready is ignored.
- Reads: when ce & rd_en, rd_data loads bank[rd_bank][rd_addr]. rd_valid is the registered value of rd_en & frame_ready.
- Simultaneous events: frame completion and release in the same cycle act on different banks, and both take effect. If wr_bank == rd_bank, that bank is not full, so release is a no-op.
- Backpressure: with both banks full, in_ready = 0. Samples offered then are dropped and set overflow.

## Timing
- Reset values: in_ready 1, frame_ready 0, rd_valid 0, rd_data 0, overflow 0.
- Write-to-frame_ready latency: frame_ready rises the cycle after the last sample is accepted.
- Read latency: 1 enabled cycle.
- Release takes effect next cycle. A read in the same cycle as rd_release returns data from the released bank.
- in_ready drops the cycle after completion of a frame into the last free bank, and rises the cycle after a release.
- Reset asserted mid-frame: all flags and pointers clear immediately. RAM contents are don't-care.

## Configuration
- FFT_FRAME_BITREV_RD_EN defined: the effective read address is bit-reverse(rd_addr), so a reader issuing natural-order addresses receives bit-reversed sample order.
- Undefined: rd_addr is used directly.
- All other behaviour is identical in both builds.

## Structure
- Shared package fft_buf_pkg:
  - DATA_W, ADDR_W defaults
  - FRAME_LEN
  - writer state enum {WAIT_SOF, FILL}
  - bitrev function
- Sub-module fft_buf_dpram: simple dual-port RAM, one write port, one registered read port, ce-gated. Instantiated once, with bank select as the address MSB.

## Test plan
- Reset, then stream samples 0..255 with in_start on the first -> frame_ready = 1 one cycle after sample 255. Reads of addresses 0, 17, 255 return 0, 17, 255 after 1 cycle with rd_valid = 1. In the bitrev build, rd_addr 1 returns 128.
- 10 samples before any in_start -> discarded. A following 256-sample frame reads back exactly that frame.
- Fill two frames with no release -> in_ready = 0. A third-frame sample sets overflow = 1. rd_release -> in_ready = 1 next cycle and frame_ready stays 1, now showing the second frame.
- in_start at wr_cnt = 100 with data 0xAAAA -> address 0 reads 0xAAAA after completion. Completion requires 255 further samples.
- rd_release in the same cycle the other bank completes -> rd_bank toggles, and frame_ready stays 1 for the new frame.
- reset_n low at wr_cnt = 50 with one bank full -> next cycle frame_ready = 0, in_ready = 1, overflow = 0, FSM in WAIT_SOF. ce low for 5 cycles mid-stream -> no counter or flag change.
